// File: rtl/signature_analyzer_misr.sv
// signature_analyzer_misr: compresses a fixed-length window of qualified
// 8-bit samples into a 16-bit multiple-input signature register (MISR).
// Optional build macro SIG_COMPARE_EN adds a registered 'pass' output that
// compares the final signature against GOLDEN.
//
// Handshake: start is a single-cycle pulse honoured in IDLE or DONE only;
// data_valid qualifies data_in on any edge while busy=1 (never in the start
// cycle); done=1 marks the signature as final and stable until the next start.
module signature_analyzer_misr #(
  parameter int              DATA_W      = 8,
  parameter int              SIG_W       = 16,
  parameter logic [SIG_W-1:0] POLY       = 16'h1021,
  parameter logic [SIG_W-1:0] SEED       = 16'h0000,
  parameter int              NUM_SAMPLES = 256,
  parameter logic [SIG_W-1:0] GOLDEN     = 16'h0000,
  localparam int             CW          = $clog2(NUM_SAMPLES + 1)
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              start,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  signature,
  output logic [CW-1:0]     sample_count
`ifdef SIG_COMPARE_EN
  ,
  output logic              pass
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_SAMPLES - 1);

  state_t           state_q;
  state_t           state_d;
  logic [SIG_W-1:0] sig_d;
  logic [CW-1:0]    cnt_d;
  logic             accept;
  logic             last_sample;

  assign accept      = (state_q == S_RUN) && data_valid;
  assign last_sample = accept && (sample_count == LAST_CNT);

  // Next-state logic: start is only honoured outside RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_sample) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (clear) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Datapath next values: reload on start, shift/feedback on accepted sample.
  always_comb begin
    sig_d = signature;
    cnt_d = sample_count;
    if ((state_q != S_RUN) && start) begin
      sig_d = SEED;
      cnt_d = '0;
    end else if (accept) begin
      sig_d = {signature[SIG_W-2:0], 1'b0}
            ^ (signature[SIG_W-1] ? POLY : {SIG_W{1'b0}})
            ^ SIG_W'(data_in);
      cnt_d = sample_count + CW'(1);
    end
  end

  // Signature and sample counter registers.
  always_ff @(posedge clk) begin
    if (clear) begin
      signature    <= SEED;
      sample_count <= '0;
    end else begin
      signature    <= sig_d;
      sample_count <= cnt_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);

`ifdef SIG_COMPARE_EN
  // Golden comparison registered so pass rises together with done.
  always_ff @(posedge clk) begin
    if (clear) pass <= 1'b0;
    else       pass <= (state_d == S_DONE) && (sig_d == GOLDEN);
  end
`endif

endmodule
